// File: rtl/led_pio_sequencer_if.sv
// rtl/led_pio_sequencer_if.sv - config slave and PIO master signal bundle for the LED sequencer
interface led_pio_sequencer_if;
    logic [1:0]  cfg_address;
    logic        cfg_chipselect;
    logic        cfg_write_n;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;

    // slave: the sequencer side (accepts config, masters the PIO)
    modport slave (
        input  cfg_address, cfg_chipselect, cfg_write_n, cfg_writedata,
        output cfg_readdata,
        output pio_address, pio_chipselect, pio_write_n, pio_writedata
    );

    modport master (
        output cfg_address, cfg_chipselect, cfg_write_n, cfg_writedata,
        input  cfg_readdata,
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata
    );
endinterface

// File: rtl/led_pio_sequencer.sv
// rtl/led_pio_sequencer.sv - autonomous LED pattern sequencer driving single-cycle PIO writes
module led_pio_sequencer #(
    parameter int LED_W         = 10,
    parameter int DIV_W         = 32,
    parameter int RESET_PATTERN = 255,
    parameter int RESET_PERIOD  = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    led_pio_sequencer_if.slave  bus
);
    localparam logic [LED_W-1:0] RST_PAT = LED_W'(RESET_PATTERN);
    localparam logic [DIV_W-1:0] RST_PER = DIV_W'(RESET_PERIOD);

    typedef enum logic [1:0] {IDLE, COUNT, WRITE} state_t;

    state_t             state, state_nxt;
    logic               enable;
    logic [1:0]         mode;
    logic [DIV_W-1:0]   period;
    logic [DIV_W-1:0]   count;
    logic [LED_W-1:0]   pattern, pat_nxt;
    logic               dir, dir_nxt;
    logic               pending;
    logic               running;
    logic               cfg_wr, wr_ctrl, wr_period, wr_pattern;
    logic               unused_wdata;

    assign cfg_wr     = bus.cfg_chipselect & ~bus.cfg_write_n;
    assign wr_ctrl    = cfg_wr && (bus.cfg_address == 2'd0);
    assign wr_period  = cfg_wr && (bus.cfg_address == 2'd1);
    assign wr_pattern = cfg_wr && (bus.cfg_address == 2'd2);
    assign running    = (state != IDLE);
    assign unused_wdata = ^bus.cfg_writedata;
    assign bus.pio_address = 2'd0;

    always_comb begin
        bus.cfg_readdata = '0;
        case (bus.cfg_address)
            2'd0:    bus.cfg_readdata = {29'd0, mode, enable};
            2'd1:    bus.cfg_readdata = 32'(period);
            2'd2:    bus.cfg_readdata = 32'(pattern);
            default: bus.cfg_readdata = (32'(pattern) << 16) | {30'd0, dir, running};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = WRITE;
            COUNT: begin
                if (!enable)                          state_nxt = IDLE;
                else if ((count >= period) || pending) state_nxt = WRITE;
            end
            WRITE:   state_nxt = enable ? COUNT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next working pattern; an all-zero pattern is a fixed point in every mode
    always_comb begin
        pat_nxt = pattern;
        dir_nxt = dir;
        if (pattern != '0) begin
            case (mode)
                2'd1: pat_nxt = (pattern << 1) | (pattern >> (LED_W-1));
                2'd2: begin
                    if (!dir) begin
                        if (pattern[LED_W-1]) begin
                            dir_nxt = 1'b1;
                            pat_nxt = pattern >> 1;
                        end else begin
                            pat_nxt = pattern << 1;
                        end
                    end else if (pattern[0]) begin
                        dir_nxt = 1'b0;
                        pat_nxt = pattern << 1;
                    end else begin
                        pat_nxt = pattern >> 1;
                    end
                end
                2'd3:    pat_nxt = ~pattern;
                default: pat_nxt = pattern;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            enable             <= 1'b0;
            mode               <= 2'd0;
            period             <= RST_PER;
            count              <= '0;
            pattern            <= RST_PAT;
            dir                <= 1'b0;
            pending            <= 1'b0;
            bus.pio_chipselect <= 1'b0;
            bus.pio_write_n    <= 1'b1;
            bus.pio_writedata  <= '0;
        end else begin
            state <= state_nxt;
            count <= (state == COUNT && state_nxt == COUNT) ? count + DIV_W'(1) : '0;

            if (wr_ctrl) begin
                enable <= bus.cfg_writedata[0];
                mode   <= bus.cfg_writedata[2:1];
            end
            if (wr_period) period <= bus.cfg_writedata[DIV_W-1:0];

            // Later assignments win: a seed write overrides the computed step, CTRL clears dir
            if (state == WRITE) begin
                pattern <= pat_nxt;
                dir     <= dir_nxt;
                pending <= 1'b0;
            end
            if (wr_pattern) begin
                pattern <= bus.cfg_writedata[LED_W-1:0];
                pending <= 1'b1;
            end
            if (wr_ctrl) dir <= 1'b0;

            bus.pio_chipselect <= (state_nxt == WRITE);
            bus.pio_write_n    <= (state_nxt != WRITE);
            if (state_nxt == WRITE) bus.pio_writedata <= 32'(pattern);
        end
    end
endmodule
